seq_multiplier_n_bits: RTL and testbench

Parametrised sequential shift-add multiplier, the clocked successor of the combinational array multiplier in arithmetic/.
- Computes one N×N product over N iterations, using a single N-bit adder instead of N-1 adders.
- Adds a start/busy/done handshake and a runtime signed/unsigned mode.
- Intended for area-constrained datapaths where multi-cycle latency is acceptable.

---
 rtl/seq_multiplier_n_bits.sv | 85 ++++++++
 tb/tb_seq_multiplier_n_bits.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_n_bits.sv
// Sequential shift-add N x N multiplier with a start/busy/done handshake and runtime signed mode.
// Optional early termination on an exhausted multiplier: define MULT_EARLY_TERM_EN.
module seq_multiplier_n_bits #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [2*N-1:0] acc, acc_step, acc_fin;
  logic [N-1:0]   mcand, mpr, a_mag, b_mag;
  logic [CW-1:0]  cnt;
  logic [N:0]     sum;
  logic           neg, last, accept;

  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  always_comb begin
    a_mag    = (signed_mode && a[N-1]) ? (~a) + N'(1) : a;
    b_mag    = (signed_mode && b[N-1]) ? (~b) + N'(1) : b;
    sum      = {1'b0, acc[2*N-1:N]} + (mpr[0] ? {1'b0, mcand} : '0);
    acc_step = {sum, acc[N-1:1]};
`ifdef MULT_EARLY_TERM_EN
    // Once the multiplier runs dry, skip the remaining zero iterations by
    // shifting out all of them at once so the product stays aligned.
    last     = (cnt == CW'(N-1)) || (mpr[N-1:1] == '0);
    acc_fin  = acc_step >> (CW'(N-1) - cnt);
`else
    last     = (cnt == CW'(N-1));
    acc_fin  = acc_step;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mpr   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
    end else if (accept) begin
      acc   <= '0;
      mcand <= a_mag;
      mpr   <= b_mag;
      cnt   <= '0;
      neg   <= signed_mode & (a[N-1] ^ b[N-1]);
    end else if (state == CALC) begin
      acc <= acc_step;
      mpr <= mpr >> 1;
      cnt <= cnt + CW'(1);
      if (last) p <= neg ? ('0 - acc_fin) : acc_fin;
    end
  end

endmodule

// File: tb/tb_seq_multiplier_n_bits.sv
// Scoreboard bench for seq_multiplier_n_bits (N=8); latency model follows MULT_EARLY_TERM_EN.
module tb_seq_multiplier_n_bits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done;
  logic [15:0] p;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [15:0] sb_q[$];
  logic [15:0] p_prev = '0;

  seq_multiplier_n_bits #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .p(p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic sm);
    logic signed [15:0] sx, sy;
    if (sm) begin
      sx = {{8{x[7]}}, x};
      sy = {{8{y[7]}}, y};
      return 16'(sx * sy);
    end
    return {8'd0, x} * {8'd0, y};
  endfunction

  function automatic int exp_lat(input logic [7:0] y, input logic sm);
`ifdef MULT_EARLY_TERM_EN
    logic [7:0] mag;
    int l;
    mag = (sm && y[7]) ? (~y) + 8'd1 : y;
    l = 1;
    for (int i = 0; i < 8; i++) if (mag[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  // Scoreboard consumer plus handshake invariants.
  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) check("busy_done_excl", 1, 0);
    if (busy === 1'b1) check("p_stable_calc", p, p_prev);
    if (done === 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_done", 1, 0);
      else check("p", p, sb_q.pop_front());
    end
    p_prev = p;
  end

  task automatic wait_done(output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) n++;
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tsm);
    int n;
    bit seen;
    @(posedge clk); #2;
    a = ta; b = tb; signed_mode = tsm; start = 1'b1;
    sb_q.push_back(model(ta, tb, tsm));
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(n, seen);
    check("done_seen", 32'(seen), 1);
    check("latency", 32'(n), 32'(exp_lat(tb, tsm)));
  endtask

  initial begin
    int n, c;
    bit seen;
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, c, dcnt;
    bit seen;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_p", 32'(p), 0);
    @(posedge clk); #2 rst_n = 1'b1;

    run_op(8'd13, 8'd11, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("p_hold", 32'(p), 32'h008F);
    end

    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd0,   8'd200, 1'b0);
    run_op(8'hFD,  8'd5,   1'b1);
    run_op(8'h80,  8'h80,  1'b1);
    run_op(8'h80,  8'd127, 1'b1);
    run_op(8'hFD,  8'd5,   1'b0);
    run_op(8'd77,  8'd1,   1'b0);
    run_op(8'd9,   8'h10,  1'b0);
    run_op(8'd201, 8'd0,   1'b1);

    // start pulsed mid-calculation must be ignored
    @(posedge clk); #2;
    a = 8'd7; b = 8'h85; signed_mode = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'd7, 8'h85, 1'b0));
    @(posedge clk); #2 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 a = 8'd2; b = 8'hFE; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(n, seen);
    check("midcalc_done_seen", 32'(seen), 1);

    // start held through DONE: back-to-back operations
    @(posedge clk); #2;
    a = 8'd3; b = 8'h81; signed_mode = 1'b0; start = 1'b1;
    sb_q.push_back(model(8'd3, 8'h81, 1'b0));
    @(posedge clk); #2;
    a = 8'd5; b = 8'hC0;
    sb_q.push_back(model(8'd5, 8'hC0, 1'b0));
    wait_done(n, seen);
    check("b2b_first_done", 32'(seen), 1);
    c = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    check("b2b_second_done", 32'(seen), 1);
    check("b2b_spacing", 32'(c), 9);

    // reset in the 4th CALC cycle aborts the operation
    @(posedge clk); #2;
    a = 8'd100; b = 8'hF0; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_p", 32'(p), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 0);
    run_op(8'd6, 8'd7, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
